// File: rtl/process_scheduler.sv
// process_scheduler: round-robin time-slice scheduler with per-slot base offsets and context-switch handshake
module process_scheduler #(
  parameter int SLOT_W = 2,
  parameter int ADDR_W = 12,
  parameter int QUANTUM_W = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [SLOT_W-1:0]        load_slot,
  input  logic [ADDR_W-1:0]        load_base,
  input  logic [QUANTUM_W-1:0]     quantum,
  input  logic                     start,
  input  logic                     instr_retire,
  input  logic                     end_of_process,
  input  logic                     switch_ack,
  output logic                     switch_req,
  output logic [SLOT_W-1:0]        next_slot,
  output logic [ADDR_W-1:0]        next_base,
  output logic [SLOT_W-1:0]        cur_slot,
  output logic                     running,
  output logic                     all_done,
  output logic [(1<<SLOT_W)-1:0]   ready_mask
);
  localparam int NPROC = 1 << SLOT_W;
  localparam logic [2:0] IDLE = 3'd0, SELECT = 3'd1, SWITCH = 3'd2, RUN = 3'd3, DONE = 3'd4;
  logic [2:0] state, state_n;
  logic [ADDR_W-1:0] base [NPROC];
  logic [QUANTUM_W-1:0] counter;
  logic preempt, hit, expire, load_ok;
  logic [SLOT_W-1:0] found;
  // first ready slot after cur_slot, wrapping, with cur_slot itself checked last
  always_comb begin
    found = '0;
    hit = 1'b0;
    for (int i = NPROC; i >= 1; i--) begin
      logic [SLOT_W-1:0] idx;
      idx = cur_slot + SLOT_W'(i);
      if (ready_mask[idx]) begin
        found = idx;
        hit = 1'b1;
      end
    end
  end
  // next-state decode; an expiring retire and end_of_process both lead to a single SELECT
  always_comb begin
    expire = instr_retire && counter == QUANTUM_W'(1);
    load_ok = load_valid && !(load_slot == cur_slot && (state == RUN || state == SWITCH));
    state_n = state;
    case (state)
      IDLE, DONE: state_n = (start && |ready_mask) ? SELECT : state;
      SELECT:     state_n = !hit ? DONE : (found == cur_slot && preempt) ? RUN : SWITCH;
      SWITCH:     state_n = switch_ack ? RUN : SWITCH;
      RUN:        state_n = (end_of_process || expire) ? SELECT : RUN;
      default:    state_n = IDLE;
    endcase
  end
  // state, registered status outputs, slot table and quantum counter
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      switch_req <= 1'b0;
      running <= 1'b0;
      all_done <= 1'b0;
      next_slot <= '0;
      next_base <= '0;
      cur_slot <= '1;
      ready_mask <= '0;
      counter <= '0;
      preempt <= 1'b0;
      for (int i = 0; i < NPROC; i++) base[i] <= '0;
    end else begin
      state <= state_n;
      switch_req <= state_n == SWITCH;
      running <= state_n == RUN;
      all_done <= state_n == DONE;
      preempt <= state == RUN && !end_of_process;
      if (load_ok) begin
        base[load_slot] <= load_base;
        ready_mask[load_slot] <= 1'b1;
      end
      if (state == RUN && end_of_process) ready_mask[cur_slot] <= 1'b0;
      if (state == SELECT && state_n == SWITCH) begin
        next_slot <= found;
        next_base <= base[found];
      end
      if (state == SWITCH && switch_ack) cur_slot <= next_slot;
      if ((state == SWITCH && switch_ack) || (state == SELECT && state_n == RUN)) counter <= quantum;
      else if (state == RUN && instr_retire && counter != '0) counter <= counter - QUANTUM_W'(1);
    end
  end
endmodule

// File: tb/tb_process_scheduler.sv
// tb_process_scheduler: directed checks of scheduling, preemption, end-of-process and reset behaviour
module tb_process_scheduler;
  logic CLK = 1'b0, reset = 1'b0;
  logic load_valid = 1'b0, start = 1'b0, instr_retire = 1'b0, end_of_process = 1'b0, switch_ack = 1'b0;
  logic [1:0] load_slot = '0;
  logic [11:0] load_base = '0;
  logic [7:0] quantum = '0;
  logic switch_req, running, all_done;
  logic [1:0] next_slot, cur_slot;
  logic [11:0] next_base;
  logic [3:0] ready_mask;
  int errors = 0, checks = 0;
  process_scheduler dut (
    .CLK(CLK), .reset(reset), .load_valid(load_valid), .load_slot(load_slot), .load_base(load_base),
    .quantum(quantum), .start(start), .instr_retire(instr_retire), .end_of_process(end_of_process),
    .switch_ack(switch_ack), .switch_req(switch_req), .next_slot(next_slot), .next_base(next_base),
    .cur_slot(cur_slot), .running(running), .all_done(all_done), .ready_mask(ready_mask)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  task automatic load(input logic [1:0] s, input logic [11:0] b);
    load_valid = 1'b1;
    load_slot = s;
    load_base = b;
    tick();
    load_valid = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic do_ack();
    switch_ack = 1'b1;
    tick();
    switch_ack = 1'b0;
  endtask
  task automatic retire();
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
  endtask
  task automatic eop();
    end_of_process = 1'b1;
    tick();
    end_of_process = 1'b0;
  endtask
  initial begin
    int drops;
    tick();
    chk("rst switch_req", 32'(switch_req), 0);
    chk("rst cur_slot", 32'(cur_slot), 3);
    chk("rst ready_mask", 32'(ready_mask), 0);
    chk("rst running", 32'(running), 0);
    chk("rst all_done", 32'(all_done), 0);
    chk("rst next_base", 32'(next_base), 0);
    reset = 1'b1;
    load(2'd0, 12'h000);
    load(2'd2, 12'h400);
    quantum = 8'd3;
    chk("rr ready_mask", 32'(ready_mask), 32'h5);
    do_start();
    chk("rr select no req", 32'(switch_req), 0);
    tick();
    chk("rr req", 32'(switch_req), 1);
    chk("rr next_slot0", 32'(next_slot), 0);
    chk("rr next_base0", 32'(next_base), 32'h000);
    tick();
    chk("rr req held", 32'(switch_req), 1);
    chk("rr not running", 32'(running), 0);
    do_ack();
    chk("rr running", 32'(running), 1);
    chk("rr req dropped", 32'(switch_req), 0);
    chk("rr cur_slot0", 32'(cur_slot), 0);
    retire();
    retire();
    chk("rr still running", 32'(running), 1);
    retire();
    chk("rr preempt select", 32'(running), 0);
    tick();
    chk("rr req2", 32'(switch_req), 1);
    chk("rr next_slot2", 32'(next_slot), 2);
    chk("rr next_base2", 32'(next_base), 32'h400);
    do_ack();
    chk("rr cur_slot2", 32'(cur_slot), 2);
    do_reset();
    load(2'd1, 12'h100);
    quantum = 8'd2;
    do_start();
    tick();
    chk("self next_slot1", 32'(next_slot), 1);
    do_ack();
    chk("self cur_slot1", 32'(cur_slot), 1);
    retire();
    chk("self run after 1", 32'(running), 1);
    retire();
    chk("self select", 32'(running), 0);
    chk("self no req sel", 32'(switch_req), 0);
    tick();
    chk("self rerun", 32'(running), 1);
    chk("self no req", 32'(switch_req), 0);
    chk("self cur_slot", 32'(cur_slot), 1);
    retire();
    chk("self reload", 32'(running), 1);
    retire();
    chk("self reload expire", 32'(running), 0);
    do_reset();
    load(2'd0, 12'h010);
    load(2'd1, 12'h020);
    quantum = 8'd2;
    do_start();
    tick();
    do_ack();
    chk("end cur_slot0", 32'(cur_slot), 0);
    retire();
    instr_retire = 1'b1;
    end_of_process = 1'b1;
    tick();
    instr_retire = 1'b0;
    end_of_process = 1'b0;
    chk("end select", 32'(running), 0);
    chk("end ready_mask", 32'(ready_mask), 32'h2);
    tick();
    chk("end req", 32'(switch_req), 1);
    chk("end next_slot", 32'(next_slot), 1);
    chk("end next_base", 32'(next_base), 32'h020);
    do_ack();
    chk("end cur_slot1", 32'(cur_slot), 1);
    eop();
    chk("end ready empty", 32'(ready_mask), 0);
    tick();
    chk("end all_done", 32'(all_done), 1);
    chk("end no req", 32'(switch_req), 0);
    do_start();
    chk("end stay done", 32'(all_done), 1);
    do_reset();
    load(2'd3, 12'h300);
    quantum = 8'd0;
    do_start();
    tick();
    chk("q0 next_slot", 32'(next_slot), 3);
    chk("q0 next_base", 32'(next_base), 32'h300);
    do_ack();
    drops = 0;
    instr_retire = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!running || switch_req) drops++;
    end
    instr_retire = 1'b0;
    chk("q0 no preempt", 32'(drops), 0);
    eop();
    chk("q0 eop select", 32'(running), 0);
    tick();
    chk("q0 done", 32'(all_done), 1);
    do_reset();
    load(2'd0, 12'h000);
    quantum = 8'd2;
    do_start();
    tick();
    do_ack();
    load(2'd0, 12'h555);
    chk("ld cur ignored", 32'(ready_mask), 32'h1);
    load(2'd1, 12'h111);
    chk("ld other", 32'(ready_mask), 32'h3);
    retire();
    retire();
    tick();
    chk("ld next_slot", 32'(next_slot), 1);
    chk("ld next_base", 32'(next_base), 32'h111);
    do_ack();
    eop();
    tick();
    chk("ld base kept slot", 32'(next_slot), 0);
    chk("ld base kept", 32'(next_base), 32'h000);
    chk("ld req", 32'(switch_req), 1);
    reset = 1'b0;
    #1;
    chk("arst req", 32'(switch_req), 0);
    chk("arst ready", 32'(ready_mask), 0);
    chk("arst cur_slot", 32'(cur_slot), 3);
    chk("arst running", 32'(running), 0);
    tick();
    reset = 1'b1;
    do_start();
    tick();
    chk("arst idle", 32'(switch_req), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/process_scheduler.md
# process_scheduler

Round-robin time-slice scheduler for the multi-process MIPS core. Holds a table of resident programs, each with its RAM/ROM base offset and a ready bit. Counts retired instructions of the running process and, on quantum expiry or end-of-process, selects the next ready slot. It then requests a context switch from the PC/offset logic and waits for acknowledgement. It sits between the control unit (end-of-process, retire pulses) and the PC/SetJumpOffset context path.

## Interface
- SLOT_W, 2, slot index width; NPROC = 2**SLOT_W slots
- ADDR_W, 12, program base offset width (matches RAM offset)
- QUANTUM_W, 8, quantum counter width
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- load_valid  in  1  write load_base into slot load_slot and set its ready bit
- load_slot  in  SLOT_W  slot to load
- load_base  in  ADDR_W  program base offset
- quantum  in  QUANTUM_W  time slice in retired instructions; 0 = no preemption
- start  in  1  begin scheduling (sampled only in IDLE/DONE)
- instr_retire  in  1  one-cycle pulse per retired instruction of running process
- end_of_process  in  1  running process executed its terminating instruction
- switch_ack  in  1  context save/restore complete
- switch_req  out  1  context switch request, held until ack
- next_slot  out  SLOT_W  slot being switched to
- next_base  out  ADDR_W  base offset of next_slot
- cur_slot  out  SLOT_W  slot currently owning the core
- running  out  1  a process owns the core (state RUN)
- all_done  out  1  no ready slots remain after scheduling started
- ready_mask  out  NPROC  ready bit per slot

## Operation
- States: IDLE, SELECT, SWITCH, RUN, DONE.
- Reset values: state IDLE; all outputs 0, except cur_slot = NPROC-1, so the first search starts at slot 0. Table bases are 0; ready bits are 0; the counter is 0.
- load_valid is accepted in every state except when load_slot == cur_slot in RUN or SWITCH. In that case the load is ignored.
- IDLE: on start, go to SELECT if ready_mask != 0. Otherwise stay in IDLE.
- SELECT (1 cycle):
  - Search slots cur_slot+1, cur_slot+2, … wrapping modulo NPROC. cur_slot is checked last.
  - If the first ready slot found is cur_slot and the entry was by preemption, reload the counter and go straight to RUN. No switch_req is issued.
  - Otherwise latch next_slot/next_base and go to SWITCH.
  - If no slot is ready, go to DONE.
- SWITCH:
  - switch_req = 1. next_slot/next_base are stable.
  - On switch_ack: cur_slot ← next_slot, counter ← quantum, switch_req drops, go to RUN.
  - Ack arriving in the same cycle switch_req first rises is valid.
- RUN:
  - running = 1. Each instr_retire decrements the counter if quantum != 0.
  - A retire with counter == 1 is preemption: go to SELECT.
  - end_of_process clears ready[cur_slot] and goes to SELECT.
  - end_of_process with a simultaneous expiring retire: end wins. The ready bit is cleared and there is a single SELECT entry.
  - quantum changes take effect at the next reload only.
- DONE: all_done = 1. On start, go to SELECT if ready_mask != 0; all_done clears on leaving DONE.
- Counter arithmetic is QUANTUM_W unsigned and never wraps. It holds at 0 when quantum = 0.
- Reset asserted mid-switch drops switch_req asynchronously and returns to IDLE with the table cleared.

## Timing
- All outputs are registered.
- start → switch_req: 2 cycles (IDLE→SELECT, SELECT→SWITCH).
- switch_ack → running = 1: next edge.
- Expiring retire or end_of_process → switch_req: 2 cycles.
- Self-reselection after preemption: running deasserts for exactly 1 cycle (SELECT).
- Retire pulses outside RUN are ignored.
- switch_ack outside SWITCH is ignored.

## Test plan
- Reset, load slots 0 (base 0x000) and 2 (base 0x400), quantum=3, start → switch_req with next_slot=0, next_base=0x000. Ack → running. 3 retires → switch_req with next_slot=2, next_base=0x400.
- Single ready slot 1, quantum=2, 2 retires → running low for 1 cycle, no switch_req, cur_slot stays 1, counter reloaded to 2.
- Slots 0 and 1 ready; end_of_process on slot 0 coinciding with its expiring retire → ready_mask=0b0010, one switch to slot 1. Then end_of_process on slot 1 → DONE, all_done=1.
- quantum=0, 1000 retires → no preemption. end_of_process → SELECT.
- Load to cur_slot during RUN → ignored, ready_mask unchanged. Load to another slot during RUN → its ready bit sets and it is selected at next preemption.
- Drop reset during SWITCH before ack → switch_req=0 immediately, state IDLE, ready_mask=0, cur_slot=NPROC-1.
